alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  - Integer ALU for the flintRV RV32I execute stage: add/sub, logic, shifts, set-less-than, pass-B, PC+4.
//  - Also produces equal, carry and signed-less-than flags; the branch unit uses these flags.
//  - All outputs are registered, so results appear one i_clk cycle after the inputs are sampled.
// PARAMETERS
//  - XLEN  32  datapath width. Shift amount = i_b[$clog2(XLEN)-1:0].
// PORTS
//  - i_clk     in   1     clock; all state updates on the rising edge.
//  - i_rst     in   1     reset; synchronous, active-high.
//  - i_a       in   XLEN  operand A.
//  - i_b       in   XLEN  operand B.
//  - i_op      in   5     operation select (ALU_EXEC_* codes).
//  - o_result  out  XLEN  registered result.
//  - o_eflag   out  1     registered: (i_a == i_b).
//  - o_cflag   out  1     registered: carry-out of i_a + ~i_b + 1; 1 iff i_a >= i_b unsigned.
//  - o_lflag   out  1     registered: $signed(i_a) < $signed(i_b).
// BEHAVIOUR
//  - Latency: 1 cycle. Inputs are sampled at edge N; outputs are valid after edge N and hold until the next edge.
//  - Reset: when i_rst=1 at an edge, o_result=0, o_eflag=0, o_cflag=0 and o_lflag=0; inputs are ignored.
//    Normal operation resumes at the first edge with i_rst=0.
//  - Flags are computed for every op, independent of i_op.
//  - Op codes and results (results wrap modulo 2^XLEN; no overflow output):
//    - 0  ADD:   a+b
//    - 1  SUB:   a-b
//    - 2  SLL:   a << sh
//    - 3  SLT:   {0, lflag}
//    - 4  SLTU:  {0, ~cflag}
//    - 5  XOR:   a^b
//    - 6  SRL:   a >> sh
//    - 7  SRA:   $signed(a) >>> sh
//    - 8  OR:    a|b
//    - 9  AND:   a&b
//    - 10 PASSB: b
//    - 11 ADD4A: a+4
//    - 12 EQ, 13 NEQ, 14 SGTE, 15 SGTEU: a-b; the branch unit decides from the flags.
//    - 16..31 (undefined): a+b (default adder path).
//  - A single shared adder/subtractor computes a + (sub ? ~b : b) + sub.
//    - sub=1 for SUB, SLT, SLTU, EQ, NEQ, SGTE and SGTEU.
//    - ADD4A reuses the adder with the B input forced to 4.
//  - lflag = (a[MSB] != b[MSB]) ? a[MSB] : diff[MSB].
//  - Boundaries:
//    - sh=0 returns a unchanged.
//    - sh=XLEN-1 is the maximum shift; the upper bits of i_b are ignored.
//    - a=b gives eflag=1 and cflag=1.
//    - 0x7FFFFFFF+1 wraps to 0x80000000.
// STRUCTURE
//  - Shared package alu_pkg: ALU_EXEC_* localparams (5-bit) and the XLEN default. The decoder imports it.
//  - One sub-module, alu_addsub: XLEN adder with sub control.
//    Outputs: sum, carry-out, lflag. Everything else stays in alu.
//  - The output register stage lives in alu.
// TESTING
//  - Reset: i_rst=1 with a=5, b=5, op=ADD -> next cycle result=0 and all flags=0.
//  - Arithmetic:
//    - ADD a=0x01010101, b=0x80808080 -> 0x81818181.
//    - SUB, same operands -> 0x80808081, cflag=0, lflag=0.
//  - Compares: a=0x01010101, b=0x80808080.
//    - SLT -> 0, lflag=0.
//    - SLTU -> 1, cflag=0.
//    - EQ with a=b=5 -> result 0, eflag=1, cflag=1.
//  - Shifts: a=0x80000000, b=0xFFFFFFE4 (sh=4).
//    - SRA -> 0xF8000000.
//    - SRL -> 0x08000000.
//    - SLL with a=1 -> 0x10.
//  - Misc:
//    - PASSB b=0xDEADBEEF -> 0xDEADBEEF.
//    - ADD4A a=0xFFFFFFFE -> 0x00000002.
//    - op=31, a=1, b=2 -> 3.
//  - Sweep: all 32 op codes x 32 vectors (a={j,j,j,j}, b=bit-reversed j replicated).
//    Check results against a reference model; check eflag whenever a==b.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the flintRV execute-stage ALU: datapath width and operation codes.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_EXEC_ADD   = 5'd0;
    localparam logic [4:0] ALU_EXEC_SUB   = 5'd1;
    localparam logic [4:0] ALU_EXEC_SLL   = 5'd2;
    localparam logic [4:0] ALU_EXEC_SLT   = 5'd3;
    localparam logic [4:0] ALU_EXEC_SLTU  = 5'd4;
    localparam logic [4:0] ALU_EXEC_XOR   = 5'd5;
    localparam logic [4:0] ALU_EXEC_SRL   = 5'd6;
    localparam logic [4:0] ALU_EXEC_SRA   = 5'd7;
    localparam logic [4:0] ALU_EXEC_OR    = 5'd8;
    localparam logic [4:0] ALU_EXEC_AND   = 5'd9;
    localparam logic [4:0] ALU_EXEC_PASSB = 5'd10;
    localparam logic [4:0] ALU_EXEC_ADD4A = 5'd11;
    localparam logic [4:0] ALU_EXEC_EQ    = 5'd12;
    localparam logic [4:0] ALU_EXEC_NEQ   = 5'd13;
    localparam logic [4:0] ALU_EXEC_SGTE  = 5'd14;
    localparam logic [4:0] ALU_EXEC_SGTEU = 5'd15;

    // Ops that drive the shared adder in subtract mode.
    function automatic logic is_sub_op(input logic [4:0] op);
        case (op)
            ALU_EXEC_SUB, ALU_EXEC_SLT, ALU_EXEC_SLTU,
            ALU_EXEC_EQ, ALU_EXEC_NEQ, ALU_EXEC_SGTE, ALU_EXEC_SGTEU: is_sub_op = 1'b1;
            default:                                                  is_sub_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// XLEN-wide adder/subtractor: sum = a + (sub ? ~b : b) + sub, with carry-out and signed-less-than.
module alu_addsub #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sub,
    output logic [XLEN-1:0] sum,
    output logic            cout,
    output logic            lflag
);

    logic [XLEN-1:0] b_eff;

    assign b_eff         = sub ? ~b : b;
    assign {cout, sum}   = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
    // Differing signs decide directly; otherwise the difference sign cannot overflow.
    assign lflag         = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : sum[XLEN-1];

endmodule

// File: rtl/alu.sv
// flintRV RV32I execute-stage ALU with registered result and branch flags (1-cycle latency).
module alu
    import alu_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [XLEN_P-1:0] i_a,
    input  logic [XLEN_P-1:0] i_b,
    input  logic [4:0]        i_op,
    output logic [XLEN_P-1:0] o_result,
    output logic              o_eflag,
    output logic              o_cflag,
    output logic              o_lflag
);

    localparam int SHW = $clog2(XLEN_P);

    logic [SHW-1:0]    sh;
    logic [XLEN_P-1:0] add_b;
    logic              add_sub;
    logic [XLEN_P-1:0] add_sum;
    logic              add_cout;
    logic              add_lflag;
    logic [XLEN_P-1:0] cmp_diff;
    logic              cmp_cout;
    logic              cmp_lflag;
    logic [XLEN_P-1:0] result_d;

    assign sh      = i_b[SHW-1:0];
    assign add_sub = is_sub_op(i_op);
    assign add_b   = (i_op == ALU_EXEC_ADD4A) ? XLEN_P'(4) : i_b;

    // Shared result path; SLT/SLTU read its flags since it is in subtract mode for them.
    alu_addsub #(.XLEN(XLEN_P)) u_addsub (
        .a     (i_a),
        .b     (add_b),
        .sub   (add_sub),
        .sum   (add_sum),
        .cout  (add_cout),
        .lflag (add_lflag)
    );

    // Dedicated subtractor so the flags are valid regardless of the selected op.
    alu_addsub #(.XLEN(XLEN_P)) u_cmp (
        .a     (i_a),
        .b     (i_b),
        .sub   (1'b1),
        .sum   (cmp_diff),
        .cout  (cmp_cout),
        .lflag (cmp_lflag)
    );

    always_comb begin
        result_d = add_sum;
        case (i_op)
            ALU_EXEC_SLL:   result_d = i_a << sh;
            ALU_EXEC_SLT:   result_d = {{(XLEN_P-1){1'b0}}, add_lflag};
            ALU_EXEC_SLTU:  result_d = {{(XLEN_P-1){1'b0}}, ~add_cout};
            ALU_EXEC_XOR:   result_d = i_a ^ i_b;
            ALU_EXEC_SRL:   result_d = i_a >> sh;
            ALU_EXEC_SRA:   result_d = $unsigned($signed(i_a) >>> sh);
            ALU_EXEC_OR:    result_d = i_a | i_b;
            ALU_EXEC_AND:   result_d = i_a & i_b;
            ALU_EXEC_PASSB: result_d = i_b;
            default:        result_d = add_sum;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_result <= '0;
            o_eflag  <= 1'b0;
            o_cflag  <= 1'b0;
            o_lflag  <= 1'b0;
        end else begin
            o_result <= result_d;
            o_eflag  <= (cmp_diff == '0);
            o_cflag  <= cmp_cout;
            o_lflag  <= cmp_lflag;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed steps, reset check and a full op x vector sweep.
module tb_alu;
    import alu_pkg::*;

    localparam int W = XLEN + 3;   // {result, eflag, cflag, lflag}

    logic            i_clk;
    logic            i_rst;
    logic [XLEN-1:0] i_a;
    logic [XLEN-1:0] i_b;
    logic [4:0]      i_op;
    logic [XLEN-1:0] o_result;
    logic            o_eflag;
    logic            o_cflag;
    logic            o_lflag;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    alu dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_op     (i_op),
        .o_result (o_result),
        .o_eflag  (o_eflag),
        .o_cflag  (o_cflag),
        .o_lflag  (o_lflag)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [2:0] model_flags(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        model_flags = {a == b, a >= b, $signed(a) < $signed(b)};
    endfunction

    function automatic logic [XLEN-1:0] model_result(input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b,
                                                     input logic [4:0] op);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            5'd0:  model_result = a + b;
            5'd1:  model_result = a - b;
            5'd2:  model_result = a << s;
            5'd3:  model_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:  model_result = (a < b) ? 32'd1 : 32'd0;
            5'd5:  model_result = a ^ b;
            5'd6:  model_result = a >> s;
            5'd7:  model_result = $unsigned($signed(a) >>> s);
            5'd8:  model_result = a | b;
            5'd9:  model_result = a & b;
            5'd10: model_result = b;
            5'd11: model_result = a + 32'd4;
            5'd12, 5'd13, 5'd14, 5'd15: model_result = a - b;
            default: model_result = a + b;
        endcase
    endfunction

    task automatic check_out(input string tag);
        logic [W-1:0] exp;
        logic [W-1:0] got;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            got = {o_result, o_eflag, o_cflag, o_lflag};
            assert (got === exp) else begin
                failures++;
                $error("FAIL %s: got=%h required=%h", tag, got, exp);
            end
        end
    endtask

    // Drive at negedge, sample #1 after the rising edge that registers the inputs.
    task automatic step(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [4:0] op, input logic [XLEN-1:0] exp_res, input string tag);
        @(negedge i_clk);
        i_a  = a;
        i_b  = b;
        i_op = op;
        exp_q.push_back({exp_res, model_flags(a, b)});
        @(posedge i_clk);
        #1;
        check_out(tag);
    endtask

    task automatic step_model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [4:0] op, input string tag);
        step(a, b, op, model_result(a, b, op), tag);
    endtask

    initial begin
        logic [7:0] j8;
        logic [7:0] r8;
        logic [XLEN-1:0] va;
        logic [XLEN-1:0] vb;

        i_rst = 1'b1;
        i_a   = 32'd5;
        i_b   = 32'd5;
        i_op  = ALU_EXEC_ADD;
        repeat (2) @(posedge i_clk);
        #1;
        exp_q.push_back('0);
        check_out("reset");

        @(negedge i_clk);
        i_rst = 1'b0;

        step(32'h01010101, 32'h80808080, ALU_EXEC_ADD,   32'h81818181, "add");
        step(32'h01010101, 32'h80808080, ALU_EXEC_SUB,   32'h80808081, "sub");
        step(32'h01010101, 32'h80808080, ALU_EXEC_SLT,   32'h00000000, "slt");
        step(32'h01010101, 32'h80808080, ALU_EXEC_SLTU,  32'h00000001, "sltu");
        step(32'd5,        32'd5,        ALU_EXEC_EQ,    32'h00000000, "eq_equal");
        step(32'h80000000, 32'hFFFFFFE4, ALU_EXEC_SRA,   32'hF8000000, "sra4");
        step(32'h80000000, 32'hFFFFFFE4, ALU_EXEC_SRL,   32'h08000000, "srl4");
        step(32'h00000001, 32'hFFFFFFE4, ALU_EXEC_SLL,   32'h00000010, "sll4");
        step(32'h00000000, 32'hDEADBEEF, ALU_EXEC_PASSB, 32'hDEADBEEF, "passb");
        step(32'hFFFFFFFE, 32'h00000000, ALU_EXEC_ADD4A, 32'h00000002, "add4a");
        step(32'h00000001, 32'h00000002, 5'd31,          32'h00000003, "op31");
        step(32'h7FFFFFFF, 32'h00000001, ALU_EXEC_ADD,   32'h80000000, "add_wrap");
        step(32'hA5A5A5A5, 32'hFFFFFFE0, ALU_EXEC_SRA,   32'hA5A5A5A5, "sra_sh0");
        step(32'h80000000, 32'h0000001F, ALU_EXEC_SRA,   32'hFFFFFFFF, "sra_sh31");
        step(32'h80000000, 32'hFFFFFFFF, ALU_EXEC_SRL,   32'h00000001, "srl_sh31");
        step(32'h00000001, 32'h0000003F, ALU_EXEC_SLL,   32'h80000000, "sll_sh31");
        step(32'hFFFFFFFF, 32'h00000001, ALU_EXEC_SLT,   32'h00000001, "slt_neg");
        step(32'hFFFFFFFF, 32'h00000001, ALU_EXEC_SLTU,  32'h00000000, "sltu_big");
        step(32'h12345678, 32'h12345678, ALU_EXEC_SGTEU, 32'h00000000, "sgteu_equal");

        // Reset mid-stream must clear the registers regardless of inputs.
        @(negedge i_clk);
        i_rst = 1'b1;
        i_a   = 32'hFFFFFFFF;
        i_b   = 32'hFFFFFFFF;
        i_op  = ALU_EXEC_PASSB;
        exp_q.push_back('0);
        @(posedge i_clk);
        #1;
        check_out("reset_mid");
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int op = 0; op < 32; op++) begin
            for (int j = 0; j < 32; j++) begin
                j8 = 8'(j);
                for (int k = 0; k < 8; k++) r8[k] = j8[7-k];
                va = {j8, j8, j8, j8};
                vb = {r8, r8, r8, r8};
                step_model(va, vb, 5'(op), "sweep");
            end
        end

        for (int n = 0; n < 64; n++) begin
            va = $urandom();
            vb = (n % 8 == 0) ? va : $urandom();
            step_model(va, vb, 5'($urandom_range(0, 31)), "random");
        end

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain: left=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
